izh_neuron_scheduler: RTL
=========================

IZH_NEURON_SCHEDULER -- requirements
Module: izh_neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4, meaning number of time-multiplexed neurons sharing one update datapath (power of two, 2..16).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning spike-event FIFO entries (power of two).
REQ-003 Reset and clock: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  when low, FSM and FIFO hold state; config writes and flag clear still act.
REQ-007 tick  in  1  timestep strobe; starts one sweep over all neurons.
REQ-008 cfg_we  in  1  config write strobe.
REQ-009 cfg_addr  in  log2(N_NEURONS)  neuron index for config write.
REQ-010 cfg_a, cfg_b  in  4 each  per-neuron shift amounts a, b.
REQ-011 cfg_i  in  8  per-neuron input current (upper 8 bits of 18-bit I).
REQ-012 dp_start  out  1  one-cycle request to shared datapath.
REQ-013 dp_v_o, dp_u_o  out  18  signed 2.16 state of dispatched neuron; dp_a_o, dp_b_o out 4; dp_i_o out 8.
REQ-014 dp_done  in  1  datapath result valid; dp_v_i, dp_u_i in 18 signed; dp_spike_i in 1.
REQ-015 spk_valid  out  1, spk_id  out  log2(N_NEURONS), spk_ready  in  1  spike-event stream.
REQ-016 busy  out  1, sweep_done  out  1, overrun  out  1, overflow  out  1, clr_flags  in  1.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; IDLE with ena and tick high -> ISSUE with index 0.
REQ-018 ISSUE lasts exactly one cycle: dp_start=1; dp_*_o driven from current index's stored v, u, a, b, i; next state WAIT.
REQ-019 dp_*_o SHALL hold stable from ISSUE through the dp_done cycle.
REQ-020 WAIT: on dp_done high, store dp_v_i/dp_u_i into current index; if index < N_NEURONS-1, increment and go ISSUE, else go IDLE and pulse sweep_done for one cycle.
REQ-021 dp_done outside WAIT SHALL be ignored.
REQ-022 busy=1 in ISSUE and WAIT, else 0.
REQ-023 tick while busy SHALL be ignored and set sticky overrun.
REQ-024 On dp_done with dp_spike_i=1, push current index into FIFO same edge.
REQ-025 Push when full and no pop: event dropped, sticky overflow set; push and pop same cycle when full: both succeed.
REQ-026 spk_valid = FIFO non-empty; pop on spk_valid and spk_ready; spk_id = oldest entry (first-word fall-through).
REQ-027 cfg_we writes a, b, i of cfg_addr next edge; write to index in ISSUE/WAIT takes effect on its next dispatch.
REQ-028 clr_flags clears overrun and overflow; a set event in the same cycle wins.
REQ-029 ena low in WAIT: dp_done ignored; datapath must re-assert dp_done after ena returns.

Reset
REQ-030 On rst_n low: state IDLE, index 0, FIFO empty, all flags 0, dp_start 0, sweep_done 0.
REQ-031 On reset every neuron v = 18'sh3_4CCD (-0.7), u = 18'sh3_CCCD (-0.2); a=0, b=0, i=0.
REQ-032 Reset asserted mid-sweep aborts immediately; partial results discarded; no spike pushed.

Verification
REQ-033 Reset then tick, datapath model returns dp_done 2 cycles after dp_start, no spikes -> 4 dp_start pulses indices 0..3, first dp_v_o=18'sh3_4CCD, sweep_done one cycle after 4th dp_done, busy 0 after.
REQ-034 cfg write addr 2 a=4 b=2 i=8'h40 -> on index-2 dispatch dp_a_o=4, dp_b_o=2, dp_i_o=8'h40; other indices 0.
REQ-035 Model spikes indices 1 and 3, spk_ready=0 -> spk_valid=1, spk_id=1 then after pop 3, then spk_valid=0.
REQ-036 spk_ready held 0, all neurons spike over 2 sweeps (8 events, depth 4) -> overflow=1, FIFO holds 0,1,2,3; clr_flags -> overflow 0.
REQ-037 tick asserted during WAIT -> overrun=1, no second sweep started, dispatch sequence unchanged.
REQ-038 rst_n low during WAIT of index 2 -> busy 0 asynchronously, all v/u return to reset values, FIFO empty.

Source files
------------

// File: rtl/izh_neuron_scheduler_if.sv
// Handshake bundle between the Izhikevich neuron scheduler, the shared
// update datapath it drives, and the downstream spike-event consumer.
interface izh_neuron_scheduler_if #(
  parameter int N_NEURONS = 4
);
  logic                           dp_start;
  logic signed [17:0]             dp_v_o;
  logic signed [17:0]             dp_u_o;
  logic [3:0]                     dp_a_o;
  logic [3:0]                     dp_b_o;
  logic [7:0]                     dp_i_o;
  logic                           dp_done;
  logic signed [17:0]             dp_v_i;
  logic signed [17:0]             dp_u_i;
  logic                           dp_spike_i;
  logic                           spk_valid;
  logic [$clog2(N_NEURONS)-1:0]   spk_id;
  logic                           spk_ready;

  modport master (
    output dp_start, dp_v_o, dp_u_o, dp_a_o, dp_b_o, dp_i_o,
    input  dp_done, dp_v_i, dp_u_i, dp_spike_i,
    output spk_valid, spk_id,
    input  spk_ready
  );

  modport slave (
    input  dp_start, dp_v_o, dp_u_o, dp_a_o, dp_b_o, dp_i_o,
    output dp_done, dp_v_i, dp_u_i, dp_spike_i,
    input  spk_valid, spk_id,
    output spk_ready
  );
endinterface

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: holds per-neuron state and
// parameters, sweeps all neurons through one shared update datapath per tick,
// and queues spiking neuron indices in a first-word fall-through FIFO.
module izh_neuron_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [3:0]                   cfg_a,
  input  logic [3:0]                   cfg_b,
  input  logic [7:0]                   cfg_i,
  input  logic                         clr_flags,
  output logic                         busy,
  output logic                         sweep_done,
  output logic                         overrun,
  output logic                         overflow,
  izh_neuron_scheduler_if.master       bus
);
  localparam int IW = $clog2(N_NEURONS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);
  localparam logic signed [17:0] V_RST = 18'sh34CCD;  // -0.7 in 2.16
  localparam logic signed [17:0] U_RST = 18'sh3CCCD;  // -0.2 in 2.16

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic signed [17:0]     v_mem [N_NEURONS];
  logic signed [17:0]     u_mem [N_NEURONS];
  logic [3:0]             a_mem [N_NEURONS];
  logic [3:0]             b_mem [N_NEURONS];
  logic [7:0]             i_mem [N_NEURONS];

  logic [IW-1:0]          fifo_mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;

  logic                   accept;
  logic                   last;
  logic                   launch;
  logic [IW-1:0]          next_idx;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   push_ok;

  // A result is only taken while waiting and enabled; stray dp_done is ignored.
  assign accept   = ena && (state == WAIT) && bus.dp_done;
  assign last     = (idx == LAST_IDX);
  assign launch   = ena && (((state == IDLE) && tick) || (accept && !last));
  assign next_idx = (state == IDLE) ? '0 : idx + 1'b1;
  assign busy     = (state != IDLE);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = accept && bus.dp_spike_i;
  assign pop      = ena && !empty && bus.spk_ready;
  // When full, a same-cycle pop frees the slot being written, so both succeed.
  assign push_ok  = push && (!full || pop);

  assign bus.spk_valid = !empty;
  assign bus.spk_id    = fifo_mem[rd_ptr[AW-1:0]];

  // Sweep sequencer: IDLE -> (ISSUE -> WAIT) per neuron -> IDLE with sweep_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bus.dp_start <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            if (tick) begin
              state        <= ISSUE;
              idx          <= '0;
              bus.dp_start <= 1'b1;
            end
          end
          ISSUE: begin
            state        <= WAIT;
            bus.dp_start <= 1'b0;
          end
          WAIT: begin
            if (bus.dp_done) begin
              if (last) begin
                state      <= IDLE;
                sweep_done <= 1'b1;
              end else begin
                idx          <= idx + 1'b1;
                state        <= ISSUE;
                bus.dp_start <= 1'b1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            bus.dp_start <= 1'b0;
          end
        endcase
      end
    end
  end

  // Neuron membrane/recovery state, written back from the datapath result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_RST;
        u_mem[k] <= U_RST;
      end
    end else if (accept) begin
      v_mem[idx] <= bus.dp_v_i;
      u_mem[idx] <= bus.dp_u_i;
    end
  end

  // Per-neuron parameters; writes act regardless of ena or sweep progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
        i_mem[k] <= '0;
      end
    end else if (cfg_we) begin
      a_mem[cfg_addr] <= cfg_a;
      b_mem[cfg_addr] <= cfg_b;
      i_mem[cfg_addr] <= cfg_i;
    end
  end

  // Snapshot the dispatched neuron so the datapath sees stable operands
  // from ISSUE until its result is accepted, even across config writes.
  always_ff @(posedge clk) begin
    if (launch) begin
      bus.dp_v_o <= v_mem[next_idx];
      bus.dp_u_o <= u_mem[next_idx];
      bus.dp_a_o <= a_mem[next_idx];
      bus.dp_b_o <= b_mem[next_idx];
      bus.dp_i_o <= i_mem[next_idx];
    end
  end

  // Spike FIFO pointers; one extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Spike FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= idx;
  end

  // Sticky error flags; a new set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (tick && busy)             overrun <= 1'b1;
      else if (clr_flags)           overrun <= 1'b0;
      if (push && full && !pop)     overflow <= 1'b1;
      else if (clr_flags)           overflow <= 1'b0;
    end
  end
endmodule
